// File: rtl/tl_fragmenter_param_if.sv
// Bus bundle between a TileLink-UL master, the fragmenter and the beat-sized slave.
// The "slave" modport is the fragmenter's view; "master" is the surrounding environment.
interface tl_fragmenter_param_if #(
    parameter int BEAT_BYTES = 8,
    parameter int MAX_IN_LG  = 7,
    parameter int SRC_W      = 3,
    parameter int ADDR_W     = 12
);
    localparam int BEAT_LG = $clog2(BEAT_BYTES);
    localparam int FRAG_W  = ((MAX_IN_LG - BEAT_LG) > 1) ? (MAX_IN_LG - BEAT_LG) : 1;
    localparam int OSZ_W   = $clog2(BEAT_LG + 1);
    localparam int XSRC_W  = SRC_W + FRAG_W;

    logic                    in_a_ready;
    logic                    in_a_valid;
    logic [2:0]              in_a_opcode;
    logic [2:0]              in_a_param;
    logic [2:0]              in_a_size;
    logic [SRC_W-1:0]        in_a_source;
    logic [ADDR_W-1:0]       in_a_address;
    logic [BEAT_BYTES-1:0]   in_a_mask;
    logic [8*BEAT_BYTES-1:0] in_a_data;
    logic                    in_a_corrupt;
    logic                    in_d_ready;
    logic                    in_d_valid;
    logic [2:0]              in_d_opcode;
    logic [2:0]              in_d_size;
    logic [SRC_W-1:0]        in_d_source;
    logic [8*BEAT_BYTES-1:0] in_d_data;
    logic                    out_a_ready;
    logic                    out_a_valid;
    logic [2:0]              out_a_opcode;
    logic [2:0]              out_a_param;
    logic [OSZ_W-1:0]        out_a_size;
    logic [XSRC_W-1:0]       out_a_source;
    logic [ADDR_W-1:0]       out_a_address;
    logic [BEAT_BYTES-1:0]   out_a_mask;
    logic [8*BEAT_BYTES-1:0] out_a_data;
    logic                    out_a_corrupt;
    logic                    out_d_ready;
    logic                    out_d_valid;
    logic [2:0]              out_d_opcode;
    logic [OSZ_W-1:0]        out_d_size;
    logic [XSRC_W-1:0]       out_d_source;
    logic [8*BEAT_BYTES-1:0] out_d_data;

    modport slave (
        output in_a_ready,
        input  in_a_valid, in_a_opcode, in_a_param, in_a_size, in_a_source,
        input  in_a_address, in_a_mask, in_a_data, in_a_corrupt,
        input  in_d_ready,
        output in_d_valid, in_d_opcode, in_d_size, in_d_source, in_d_data,
        input  out_a_ready,
        output out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source,
        output out_a_address, out_a_mask, out_a_data, out_a_corrupt,
        output out_d_ready,
        input  out_d_valid, out_d_opcode, out_d_size, out_d_source, out_d_data
    );

    modport master (
        input  in_a_ready,
        output in_a_valid, in_a_opcode, in_a_param, in_a_size, in_a_source,
        output in_a_address, in_a_mask, in_a_data, in_a_corrupt,
        output in_d_ready,
        input  in_d_valid, in_d_opcode, in_d_size, in_d_source, in_d_data,
        output out_a_ready,
        input  out_a_valid, out_a_opcode, out_a_param, out_a_size, out_a_source,
        input  out_a_address, out_a_mask, out_a_data, out_a_corrupt,
        input  out_d_ready,
        output out_d_valid, out_d_opcode, out_d_size, out_d_source, out_d_data
    );
endinterface

// File: rtl/tl_fragmenter_param.sv
// TileLink-UL fragmenter: splits multi-beat Get/Put into beat-sized fragments and
// folds the fragment responses back into one logical transaction for the master.
module tl_fragmenter_param #(
    parameter int BEAT_BYTES = 8,
    parameter int MAX_IN_LG  = 7,
    parameter int SRC_W      = 3,
    parameter int ADDR_W     = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    tl_fragmenter_param_if.slave  bus,
    output logic                  proto_err
);
    localparam int BEAT_LG = $clog2(BEAT_BYTES);
    localparam int FRAG_W  = ((MAX_IN_LG - BEAT_LG) > 1) ? (MAX_IN_LG - BEAT_LG) : 1;
    localparam int OSZ_W   = $clog2(BEAT_LG + 1);
    localparam int XSRC_W  = SRC_W + FRAG_W;
    localparam int SRC_N   = 1 << SRC_W;

    logic [FRAG_W-1:0] frag_idx_r;
    logic [FRAG_W-1:0] frag_idx_nxt_s;
    logic [FRAG_W-1:0] last_idx_s;
    logic [FRAG_W-1:0] frag_rem_s;
    logic [FRAG_W:0]   n_beats_s;
    logic [2:0]        shift_s;
    logic [2:0]        size_tbl_r [SRC_N];
    logic [ADDR_W-1:0] align_mask_s;
    logic [ADDR_W-1:0] addr_s;
    logic              legal_op_s;
    logic              misalign_s;
    logic              illegal_s;
    logic              multi_s;
    logic              is_get_s;
    logic              hold_s;
    logic              a_fire_s;
    logic              in_fire_s;
    logic [SRC_W-1:0]  d_src_s;
    logic [FRAG_W-1:0] d_rem_s;
    logic              swallow_s;
    logic              unused_s;

    // Request classification, fragment count and handshake steering.
    always_comb begin
        legal_op_s   = (bus.in_a_opcode == 3'd0) || (bus.in_a_opcode == 3'd1) ||
                       (bus.in_a_opcode == 3'd4);
        align_mask_s = (ADDR_W'(1) << bus.in_a_size) - ADDR_W'(1);
        misalign_s   = |(bus.in_a_address & align_mask_s);
        illegal_s    = !legal_op_s || (int'(bus.in_a_size) > MAX_IN_LG) || misalign_s;
        // Illegal requests are forwarded untouched as a single fragment.
        multi_s      = !illegal_s && (int'(bus.in_a_size) > BEAT_LG);
        is_get_s     = (bus.in_a_opcode == 3'd4);
        shift_s      = multi_s ? (bus.in_a_size - 3'(BEAT_LG)) : 3'd0;
        n_beats_s    = (FRAG_W+1)'(1) << shift_s;
        last_idx_s   = FRAG_W'(n_beats_s - (FRAG_W+1)'(1));
        frag_rem_s   = last_idx_s - frag_idx_r;
        hold_s       = multi_s && is_get_s && (frag_idx_r != last_idx_s);
        a_fire_s     = bus.in_a_valid && bus.out_a_ready;
        in_fire_s    = bus.in_a_valid && bus.in_a_ready;
        if (!a_fire_s) begin
            frag_idx_nxt_s = frag_idx_r;
        end else if (multi_s && (frag_idx_r != last_idx_s)) begin
            frag_idx_nxt_s = frag_idx_r + FRAG_W'(1);
        end else begin
            frag_idx_nxt_s = '0;
        end
        if (multi_s) begin
            addr_s = (bus.in_a_address & ~ADDR_W'(BEAT_BYTES - 1)) +
                     (ADDR_W'(frag_idx_r) << BEAT_LG);
        end else begin
            addr_s = bus.in_a_address;
        end
    end

    assign bus.in_a_ready    = bus.out_a_ready && !hold_s;
    assign bus.out_a_valid   = bus.in_a_valid;
    assign bus.out_a_opcode  = bus.in_a_opcode;
    assign bus.out_a_param   = bus.in_a_param;
    assign bus.out_a_size    = (int'(bus.in_a_size) > BEAT_LG) ? OSZ_W'(BEAT_LG)
                                                              : OSZ_W'(bus.in_a_size);
    assign bus.out_a_source  = {bus.in_a_source, frag_rem_s};
    assign bus.out_a_address = addr_s;
    assign bus.out_a_mask    = (multi_s && is_get_s) ? {BEAT_BYTES{1'b1}} : bus.in_a_mask;
    assign bus.out_a_data    = bus.in_a_data;
    assign bus.out_a_corrupt = bus.in_a_corrupt;

    // Responses for non-final write fragments are absorbed here.
    assign d_src_s         = bus.out_d_source[XSRC_W-1:FRAG_W];
    assign d_rem_s         = bus.out_d_source[FRAG_W-1:0];
    assign swallow_s       = (bus.out_d_opcode == 3'd0) && (|d_rem_s);
    assign bus.in_d_valid  = bus.out_d_valid && !swallow_s;
    assign bus.out_d_ready = swallow_s || bus.in_d_ready;
    assign bus.in_d_opcode = bus.out_d_opcode;
    assign bus.in_d_size   = size_tbl_r[d_src_s];
    assign bus.in_d_source = d_src_s;
    assign bus.in_d_data   = bus.out_d_data;
    assign unused_s        = ^bus.out_d_size;

    // Fragment index and sticky protocol-error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frag_idx_r <= '0;
            proto_err  <= 1'b0;
        end else begin
            frag_idx_r <= frag_idx_nxt_s;
            proto_err  <= proto_err || (in_fire_s && illegal_s);
        end
    end

    // Original request size per source, captured on the first fragment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SRC_N; i++) begin
                size_tbl_r[i] <= 3'd0;
            end
        end else if (a_fire_s && (frag_idx_r == '0)) begin
            size_tbl_r[bus.in_a_source] <= bus.in_a_size;
        end
    end
endmodule

// File: tb/tb_tl_fragmenter_param.sv
// Directed self-checking bench for tl_fragmenter_param (default parameters).
module tb_tl_fragmenter_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic proto_err;
    int   checks = 0;
    int   errors = 0;

    tl_fragmenter_param_if #(.BEAT_BYTES(8), .MAX_IN_LG(7), .SRC_W(3), .ADDR_W(12)) bus ();

    tl_fragmenter_param #(.BEAT_BYTES(8), .MAX_IN_LG(7), .SRC_W(3), .ADDR_W(12)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .proto_err (proto_err)
    );

    always #5 clock = ~clock;

    task automatic set_a(input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [2:0] src, input logic [11:0] addr,
                         input logic [7:0] mask, input logic [63:0] data);
        bus.in_a_valid   = v;
        bus.in_a_opcode  = op;
        bus.in_a_param   = 3'd0;
        bus.in_a_size    = sz;
        bus.in_a_source  = src;
        bus.in_a_address = addr;
        bus.in_a_mask    = mask;
        bus.in_a_data    = data;
        bus.in_a_corrupt = 1'b0;
    endtask

    task automatic set_d(input logic v, input logic [2:0] op, input logic [6:0] src,
                         input logic [63:0] data, input logic rdy);
        bus.out_d_valid  = v;
        bus.out_d_opcode = op;
        bus.out_d_size   = 2'd3;
        bus.out_d_source = src;
        bus.out_d_data   = data;
        bus.in_d_ready   = rdy;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        set_a(1'b0, 3'd0, 3'd0, 3'd0, 12'h000, 8'h00, 64'd0);
        set_d(1'b0, 3'd0, 7'd0, 64'd0, 1'b0);
        bus.out_a_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        got = {bus.in_a_ready, bus.out_a_valid, bus.in_d_valid, bus.out_d_ready,
               proto_err, bus.in_d_size};
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", got, 8'h00);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_get_burst();
        logic [30:0] got, exp_v;
        logic [13:0] dgot, dexp;
        @(negedge clock);
        bus.out_a_ready = 1'b1;
        set_a(1'b1, 3'd4, 3'd6, 3'd5, 12'h040, 8'h0F, 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            got   = {bus.out_a_valid, bus.out_a_address, bus.out_a_source, bus.out_a_size,
                     bus.out_a_mask, bus.in_a_ready};
            exp_v = {1'b1, 12'h040 + 12'(8 * i), 3'd5, 4'(7 - i), 2'd3, 8'hFF, (i == 7)};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL get_frag[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
        @(negedge clock);
        set_a(1'b0, 3'd0, 3'd0, 3'd0, 12'h000, 8'h00, 64'd0);
        for (int i = 0; i < 8; i++) begin
            set_d(1'b1, 3'd1, {3'd5, 4'(7 - i)}, 64'h0101010101010101 * 64'(i), 1'b1);
            #1;
            dgot = {bus.in_d_valid, bus.in_d_opcode, bus.in_d_size, bus.in_d_source,
                    bus.out_d_ready, (bus.in_d_data == 64'h0101010101010101 * 64'(i))};
            dexp = {1'b1, 3'd1, 3'd6, 3'd5, 1'b1, 1'b1};
            checks++;
            if (dgot !== dexp) begin
                errors++;
                $display("FAIL get_resp[%0d]: got %h expected %h", i, dgot, dexp);
            end
            @(negedge clock);
        end
        set_d(1'b0, 3'd0, 7'd0, 64'd0, 1'b0);
    endtask

    task automatic test_put_burst();
        logic [96:0] got, exp_v;
        logic [63:0] data;
        logic [1:0]  hs;
        logic [8:0]  dinfo;
        for (int i = 0; i < 4; i++) begin
            data = 64'hA5A5_0000_0000_0000 + 64'(i);
            set_a(1'b1, 3'd0, 3'd5, 3'd2, 12'h0A0, 8'hFF, data);
            #1;
            got   = {bus.out_a_address, bus.out_a_source, bus.out_a_size, bus.out_a_mask,
                     bus.out_a_data, bus.in_a_ready, bus.out_a_opcode};
            exp_v = {12'h0A0 + 12'(8 * i), 3'd2, 4'(3 - i), 2'd3, 8'hFF, data, 1'b1, 3'd0};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL put_frag[%0d]: got %h expected %h", i, got, exp_v);
            end
            @(negedge clock);
        end
        set_a(1'b0, 3'd0, 3'd0, 3'd0, 12'h000, 8'h00, 64'd0);
        for (int i = 0; i < 4; i++) begin
            set_d(1'b1, 3'd0, {3'd2, 4'(3 - i)}, 64'd0, (i == 3));
            #1;
            hs = {bus.in_d_valid, bus.out_d_ready};
            checks++;
            if (hs !== ((i < 3) ? 2'b01 : 2'b11)) begin
                errors++;
                $display("FAIL put_ack_hs[%0d]: got %b expected %b", i, hs,
                         ((i < 3) ? 2'b01 : 2'b11));
            end
            if (i == 3) begin
                dinfo = {bus.in_d_opcode, bus.in_d_size, bus.in_d_source};
                checks++;
                if (dinfo !== {3'd0, 3'd5, 3'd2}) begin
                    errors++;
                    $display("FAIL put_ack_fields: got %h expected %h", dinfo,
                             {3'd0, 3'd5, 3'd2});
                end
            end
            @(negedge clock);
        end
        set_d(1'b0, 3'd0, 7'd0, 64'd0, 1'b0);
    endtask

    task automatic test_passthrough();
        logic [29:0] got, exp_v;
        logic [6:0]  dgot;
        set_a(1'b1, 3'd4, 3'd2, 3'd3, 12'h104, 8'hF0, 64'd0);
        #1;
        got   = {bus.out_a_address, bus.out_a_source, bus.out_a_size, bus.out_a_mask,
                 bus.in_a_ready};
        exp_v = {12'h104, 3'd3, 4'd0, 2'd2, 8'hF0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL pass_req: got %h expected %h", got, exp_v);
        end
        @(negedge clock);
        set_a(1'b0, 3'd0, 3'd0, 3'd0, 12'h000, 8'h00, 64'd0);
        set_d(1'b1, 3'd1, {3'd3, 4'd0}, 64'd0, 1'b1);
        #1;
        dgot = {bus.in_d_valid, bus.in_d_size, bus.in_d_source};
        checks++;
        if (dgot !== {1'b1, 3'd2, 3'd3}) begin
            errors++;
            $display("FAIL pass_resp: got %h expected %h", dgot, {1'b1, 3'd2, 3'd3});
        end
        @(negedge clock);
        set_d(1'b0, 3'd0, 7'd0, 64'd0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [3:0]  pat = 4'b1001;
        logic        rdy;
        int          fires = 0;
        logic [19:0] got, exp_v;
        set_a(1'b1, 3'd4, 3'd6, 3'd1, 12'h080, 8'h00, 64'd0);
        for (int c = 0; c < 20; c++) begin
            if (fires == 8) break;
            rdy = (c < 4) ? pat[c] : 1'b1;
            bus.out_a_ready = rdy;
            #1;
            got   = {bus.out_a_address, bus.out_a_source, bus.in_a_ready};
            exp_v = {12'h080 + 12'(8 * fires), 3'd1, 4'(7 - fires), rdy && (fires == 7)};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL bp_cycle[%0d]: got %h expected %h", c, got, exp_v);
            end
            @(negedge clock);
            if (rdy) fires++;
        end
        checks++;
        if (fires != 8) begin
            errors++;
            $display("FAIL bp_fire_count: got %0d expected %0d", fires, 8);
        end
        set_a(1'b0, 3'd0, 3'd0, 3'd0, 12'h000, 8'h00, 64'd0);
        bus.out_a_ready = 1'b1;
    endtask

    task automatic test_proto_err();
        logic [98:0] got, exp_v;
        set_a(1'b1, 3'd2, 3'd3, 3'd4, 12'h010, 8'h3C, 64'h0123_4567_89AB_CDEF);
        #1;
        got   = {bus.out_a_opcode, bus.out_a_size, bus.out_a_address, bus.out_a_source,
                 bus.out_a_mask, bus.out_a_data, bus.in_a_ready, proto_err};
        exp_v = {3'd2, 2'd3, 12'h010, 3'd4, 4'd0, 8'h3C, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL perr_pass: got %h expected %h", got, exp_v);
        end
        @(negedge clock);
        set_a(1'b0, 3'd0, 3'd0, 3'd0, 12'h000, 8'h00, 64'd0);
        #1;
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_rise: got %b expected %b", proto_err, 1'b1);
        end
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: got %b expected %b", proto_err, 1'b1);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [19:0] got, exp_v;
        @(negedge clock);
        set_a(1'b1, 3'd4, 3'd6, 3'd6, 12'h200, 8'h00, 64'd0);
        repeat (3) @(negedge clock);
        #1;
        got = {bus.out_a_address, bus.out_a_source, proto_err};
        checks++;
        if (got !== {12'h218, 3'd6, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL rst_pre: got %h expected %h", got, {12'h218, 3'd6, 4'd4, 1'b1});
        end
        reset = 1'b1;
        #1;
        got = {bus.out_a_address, bus.out_a_source, proto_err};
        checks++;
        if (got !== {12'h200, 3'd6, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL rst_async: got %h expected %h", got, {12'h200, 3'd6, 4'd7, 1'b0});
        end
        @(negedge clock);
        reset = 1'b0;
        set_a(1'b1, 3'd4, 3'd6, 3'd2, 12'h300, 8'h00, 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            got   = {bus.out_a_address, bus.out_a_source, bus.in_a_ready};
            exp_v = {12'h300 + 12'(8 * i), 3'd2, 4'(7 - i), (i == 7)};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL rst_new_get[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
        @(negedge clock);
        set_a(1'b0, 3'd0, 3'd0, 3'd0, 12'h000, 8'h00, 64'd0);
    endtask

    task automatic test_misaligned();
        logic [17:0] got;
        set_a(1'b1, 3'd4, 3'd3, 3'd0, 12'h004, 8'hFF, 64'd0);
        #1;
        got = {bus.out_a_address, bus.out_a_size, bus.out_a_mask[3:0]};
        checks++;
        if (got !== {12'h004, 2'd3, 4'hF}) begin
            errors++;
            $display("FAIL misalign_pass: got %h expected %h", got, {12'h004, 2'd3, 4'hF});
        end
        @(negedge clock);
        set_a(1'b0, 3'd0, 3'd0, 3'd0, 12'h000, 8'h00, 64'd0);
        #1;
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_err: got %b expected %b", proto_err, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_get_burst();
        test_put_burst();
        test_passthrough();
        test_backpressure();
        test_proto_err();
        test_reset_mid_burst();
        test_misaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_fragmenter_param.md
Name: tl_fragmenter_param

Overview:
Parametrised TileLink-UL fragmenter for the periphery bus. Splits A-channel Get/Put requests larger than one data beat into beat-sized fragments on the out port. Encodes the fragment index into an extended source ID. On the D channel it reassembles responses so the in-side master sees one logical transaction with its original size. This is the generalised successor of the fixed 8-byte/3-bit-source fragmenter: beat width, maximum request size, source and address widths are all parameters, and it adds a protocol-error flag.

Parameters:
BEAT_BYTES, 8, data-bus bytes; power of two, 4..32. Fragment size equals BEAT_BYTES.
MAX_IN_LG, 7, log2 of the largest in-side transfer in bytes; must be ≥ log2(BEAT_BYTES).
SRC_W, 3, in-side source width.
ADDR_W, 12, address width.
Derived values:
- BEAT_LG = log2(BEAT_BYTES).
- FRAG_W = max(1, MAX_IN_LG-BEAT_LG).
- OSZ_W = clog2(BEAT_LG+1).

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high reset
in_a_ready  out  1  A ready to master
in_a_valid  in  1  A valid
in_a_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get; others see proto_err
in_a_param  in  3  passed through
in_a_size  in  3  log2 bytes
in_a_source  in  SRC_W  master source
in_a_address  in  ADDR_W  aligned to size
in_a_mask  in  BEAT_BYTES  byte mask
in_a_data  in  8*BEAT_BYTES  write data
in_a_corrupt  in  1  passed through
in_d_ready  in  1  D ready from master
in_d_valid  out  1  D valid
in_d_opcode  out  3  AccessAck(0)/AccessAckData(1)
in_d_size  out  3  original request size
in_d_source  out  SRC_W  original source
in_d_data  out  8*BEAT_BYTES  read data
out_a_ready  in  1  slave ready
out_a_valid  out  1  fragment valid
out_a_opcode  out  3  copied
out_a_param  out  3  copied
out_a_size  out  OSZ_W  min(in_a_size, BEAT_LG)
out_a_source  out  SRC_W+FRAG_W  {in_a_source, frag_remaining}
out_a_address  out  ADDR_W  base + frag_idx*BEAT_BYTES
out_a_mask  out  BEAT_BYTES  Get >1 beat: all ones; else in_a_mask
out_a_data  out  8*BEAT_BYTES  in_a_data
out_a_corrupt  out  1  in_a_corrupt
out_d_ready  out  1  D ready to slave
out_d_valid  in  1  response valid
out_d_opcode  in  3  response opcode
out_d_size  in  OSZ_W  fragment size
out_d_source  in  SRC_W+FRAG_W  extended source
out_d_data  in  8*BEAT_BYTES  response data
proto_err  out  1  sticky illegal-request flag

Behaviour:
Reset:
- frag_idx=0.
- size table cleared to 0.
- proto_err=0.
- All valid outputs follow their combinational inputs; with inputs idle they are 0.

Fragment count:
- N = 2^(in_a_size-BEAT_LG) when in_a_size > BEAT_LG, else 1.
- frag_remaining = N-1-frag_idx, FRAG_W bits.

A channel (zero latency, fully combinational data path, frag_idx is the only A state):
- out_a_valid = in_a_valid.
- Get, N>1:
  - The in beat is held while fragments issue: in_a_ready = out_a_ready && frag_idx==N-1.
  - Each out_a fire increments frag_idx; the last fire wraps it to 0.
- Put, N>1: 1:1 beat-to-fragment. in_a_ready = out_a_ready; each fire increments frag_idx, wrapping to 0 after N-1.
- N==1: transparent pass-through, frag_remaining=0, frag_idx stays 0.
- Address low BEAT_LG bits are forced to 0 for N>1.

Size table:
- SRC entries of 3 bits.
- Written with in_a_size at the out_a fire where frag_idx==0.
- Read on D by out_d_source[SRC_W+FRAG_W-1:FRAG_W].

D channel (combinational):
- AccessAckData (opcode 1): forwarded 1:1. in_d_valid=out_d_valid, out_d_ready=in_d_ready, in_d_size=table entry.
- AccessAck (opcode 0) with frag_remaining≠0: swallowed. out_d_ready=1, in_d_valid=0.
- AccessAck with frag_remaining==0: forwarded with the table size.
- in_d_source = upper SRC_W bits of out_d_source.

proto_err is set, sticky until reset, on an in_a fire when any of these holds:
- opcode is not in {0,1,4};
- in_a_size > MAX_IN_LG;
- address is misaligned to in_a_size.

Illegal requests are still forwarded as N=1 passthrough.

Boundaries:
- out_a_ready low mid-burst: frag_idx holds and all out_a fields stay stable.
- in_a_valid must not drop mid-Get (TileLink rule); behaviour is undefined if it does.
- Simultaneous A write and D read of the same table entry: D sees the old value (the master cannot reuse an in-flight source).
- Asynchronous reset mid-burst: frag_idx returns to 0 immediately; in-flight responses after reset are don't-care.

Test Plan:
1. Get size 6 (64 B), addr 0x040, src 5, out_a_ready=1 -> 8 fragments over 8 cycles:
   - addresses 0x040..0x078, out_source {5,7}..{5,0}, out_size 3;
   - in_a_ready high only in cycle 8;
   - 8 AccessAckData beats return with in_d_size 6, src 5.
2. PutFull size 5 (32 B), 4 beats, src 2 -> 4 out fragments; only the response with source {2,0} reaches in_d as AccessAck size 5; the other 3 acks are consumed with in_d_valid=0.
3. Get size 2 addr 0x104 mask 0xF0 -> single passthrough; out_size 2, out_source {src,0}, mask 0xF0; response size 2.
4. Backpressure: out_a_ready toggles 1,0,0,1 during a 64 B Get -> no fragment skipped or repeated; frag_idx holds while out_a_ready=0.
5. Opcode 2 size 3 -> proto_err rises the cycle after the fire and stays 1; the request is passed through unchanged.
6. Reset asserted after fragment 3 of 8 -> frag_idx=0 and proto_err=0 immediately; a new Get then starts at fragment 0.
